// File: rtl/svpwm_capture_module.sv
// svpwm_capture_module
//
// Inverter-side monitor for the six SVPWM gate commands. For each PWM period it counts the
// cycles in which each phase's low-side switch is on ({hi,lo} == 01) and the total period length,
// which recovers the applied Tcma/Tcmb/Tcmc duty. It also flags shoot-through (both switches of a
// leg on) and a missing period sync. Results feed diagnostics and the protection path.
//
// Configuration macro: SVPWM_CAP_INPUT_SYNC_EN
//   defined   - the six gate inputs and period_start_in pass through a 2-flop synchroniser, so
//               every response is delayed by 2 cycles (relative alignment unchanged).
//   undefined - inputs are used directly and must be sys_clk-synchronous.
//
// Ports
//   sys_clk, reset_n                clock, asynchronous active-low reset
//   capture_enable_in               arm capture; low forces idle and aborts a running period
//   period_start_in                 1-cycle pulse at carrier counter == 0
//   fault_clear_in                  clears the sticky fault flags (a simultaneous set wins)
//   phase_{a,b,c}_{high,low}_in     gate commands per phase
//   phase_{a,b,c}_low_time_out      low-side-on cycles of the last full period
//   period_cycles_out               length of the last full period
//   capture_valid_out               1-cycle pulse when a new capture is published
//   overflow_out                    a counter saturated during the last published period
//   shoot_through_fault_out         sticky shoot-through flag
//   phase_fault_id_out              sticky per-phase shoot-through mask {c,b,a}
//   period_timeout_out              sticky: period_start missing for TIMEOUT_CYCLES

module svpwm_capture_module #(
  parameter int unsigned CNT_WIDTH      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                 sys_clk,
  input  logic                 reset_n,
  input  logic                 capture_enable_in,
  input  logic                 period_start_in,
  input  logic                 fault_clear_in,
  input  logic                 phase_a_high_in,
  input  logic                 phase_a_low_in,
  input  logic                 phase_b_high_in,
  input  logic                 phase_b_low_in,
  input  logic                 phase_c_high_in,
  input  logic                 phase_c_low_in,
  output logic [CNT_WIDTH-1:0] phase_a_low_time_out,
  output logic [CNT_WIDTH-1:0] phase_b_low_time_out,
  output logic [CNT_WIDTH-1:0] phase_c_low_time_out,
  output logic [CNT_WIDTH-1:0] period_cycles_out,
  output logic                 capture_valid_out,
  output logic                 overflow_out,
  output logic                 shoot_through_fault_out,
  output logic [2:0]           phase_fault_id_out,
  output logic                 period_timeout_out
);

  typedef enum logic [0:0] {
    StIdle    = 1'b0,
    StMeasure = 1'b1
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CntMax     = '1;
  localparam logic [CNT_WIDTH-1:0] CntOne     = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] TimeoutVal = CNT_WIDTH'(TIMEOUT_CYCLES);
  // A timeout beyond the counter range can never be reached by the saturating counter.
  localparam bit TimeoutFits = (64'(TIMEOUT_CYCLES) <= ((64'd1 << CNT_WIDTH) - 64'd1));

  // Packed input vector: {start, c_hi, c_lo, b_hi, b_lo, a_hi, a_lo}
  logic [6:0] raw_in;
  logic [6:0] gate_in;

  assign raw_in = {period_start_in, phase_c_high_in, phase_c_low_in, phase_b_high_in,
                   phase_b_low_in, phase_a_high_in, phase_a_low_in};

`ifdef SVPWM_CAP_INPUT_SYNC_EN
  logic [6:0] sync1_q;
  logic [6:0] sync2_q;

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
    end
  end

  assign gate_in = sync2_q;
`else
  assign gate_in = raw_in;
`endif

  logic [2:0] hi;
  logic [2:0] lo;
  logic [2:0] low_on;
  logic [2:0] shoot;
  logic       start;
  logic       timeout_hit;

  assign lo          = {gate_in[4], gate_in[2], gate_in[0]};
  assign hi          = {gate_in[5], gate_in[3], gate_in[1]};
  assign start       = gate_in[6];
  assign low_on      = ~hi & lo;
  assign shoot       = hi & lo;

  state_e                        state_q, state_d;
  logic [CNT_WIDTH-1:0]          period_cnt_q, period_cnt_d;
  logic [2:0][CNT_WIDTH-1:0]     low_cnt_q, low_cnt_d;
  logic                          ovf_q, ovf_d;
  logic [2:0][CNT_WIDTH-1:0]     cap_low_q, cap_low_d;
  logic [CNT_WIDTH-1:0]          cap_period_q, cap_period_d;
  logic                          cap_ovf_q, cap_ovf_d;
  logic                          valid_q, valid_d;
  logic                          fault_q, fault_d;
  logic [2:0]                    fault_id_q, fault_id_d;
  logic                          timeout_q, timeout_d;

  assign timeout_hit = TimeoutFits && (period_cnt_q == TimeoutVal);

  always_comb begin
    state_d      = state_q;
    period_cnt_d = period_cnt_q;
    low_cnt_d    = low_cnt_q;
    ovf_d        = ovf_q;
    cap_low_d    = cap_low_q;
    cap_period_d = cap_period_q;
    cap_ovf_d    = cap_ovf_q;
    valid_d      = 1'b0;
    timeout_d    = timeout_q & ~fault_clear_in;

    unique case (state_q)
      StIdle: begin
        period_cnt_d = '0;
        low_cnt_d    = '0;
        ovf_d        = 1'b0;
        if (capture_enable_in && start) begin
          // The start cycle itself is the first cycle of the new period.
          state_d      = StMeasure;
          period_cnt_d = CntOne;
          for (int i = 0; i < 3; i++) low_cnt_d[i] = CNT_WIDTH'(low_on[i]);
        end
      end

      StMeasure: begin
        if (!capture_enable_in) begin
          state_d      = StIdle;
          period_cnt_d = '0;
          low_cnt_d    = '0;
          ovf_d        = 1'b0;
        end else if (start) begin
          // Publish counts up to the previous cycle, then restart on this cycle.
          cap_low_d    = low_cnt_q;
          cap_period_d = period_cnt_q;
          cap_ovf_d    = ovf_q;
          valid_d      = 1'b1;
          period_cnt_d = CntOne;
          for (int i = 0; i < 3; i++) low_cnt_d[i] = CNT_WIDTH'(low_on[i]);
          ovf_d        = 1'b0;
        end else if (timeout_hit) begin
          timeout_d    = 1'b1;
          state_d      = StIdle;
          period_cnt_d = '0;
          low_cnt_d    = '0;
          ovf_d        = 1'b0;
        end else begin
          if (period_cnt_q == CntMax) begin
            ovf_d = 1'b1;
          end else begin
            period_cnt_d = period_cnt_q + CntOne;
          end
          for (int i = 0; i < 3; i++) begin
            if (low_on[i]) begin
              if (low_cnt_q[i] == CntMax) begin
                ovf_d = 1'b1;
              end else begin
                low_cnt_d[i] = low_cnt_q[i] + CntOne;
              end
            end
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // Shoot-through is monitored in every state; a set in the same cycle as a clear wins.
  always_comb begin
    fault_d    = (|shoot) | (fault_q & ~fault_clear_in);
    fault_id_d = shoot | (fault_id_q & ~{3{fault_clear_in}});
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      period_cnt_q <= '0;
      low_cnt_q    <= '0;
      ovf_q        <= 1'b0;
      cap_low_q    <= '0;
      cap_period_q <= '0;
      cap_ovf_q    <= 1'b0;
      valid_q      <= 1'b0;
      fault_q      <= 1'b0;
      fault_id_q   <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_cnt_q <= period_cnt_d;
      low_cnt_q    <= low_cnt_d;
      ovf_q        <= ovf_d;
      cap_low_q    <= cap_low_d;
      cap_period_q <= cap_period_d;
      cap_ovf_q    <= cap_ovf_d;
      valid_q      <= valid_d;
      fault_q      <= fault_d;
      fault_id_q   <= fault_id_d;
      timeout_q    <= timeout_d;
    end
  end

  assign phase_a_low_time_out    = cap_low_q[0];
  assign phase_b_low_time_out    = cap_low_q[1];
  assign phase_c_low_time_out    = cap_low_q[2];
  assign period_cycles_out       = cap_period_q;
  assign capture_valid_out       = valid_q;
  assign overflow_out            = cap_ovf_q;
  assign shoot_through_fault_out = fault_q;
  assign phase_fault_id_out      = fault_id_q;
  assign period_timeout_out      = timeout_q;

endmodule
